// File: rtl/dac_pattern_gen_if.sv
// Control and video-output bundle for dac_pattern_gen.
// The generator uses the master modport; the video sink or test driver uses slave.
interface dac_pattern_gen_if #(
    parameter int COLOR_W = 8
);
    logic               PCLK_EN;
    logic [1:0]         MODE;
    logic               FREEZE;
    logic [COLOR_W-1:0] VGA_R;
    logic [COLOR_W-1:0] VGA_G;
    logic [COLOR_W-1:0] VGA_B;
    logic               HSYNC;
    logic               VSYNC;
    logic               HBLANK;
    logic               VBLANK;
    logic               FRAME_START;

    modport master (
        input  PCLK_EN, MODE, FREEZE,
        output VGA_R, VGA_G, VGA_B, HSYNC, VSYNC, HBLANK, VBLANK, FRAME_START
    );

    modport slave (
        output PCLK_EN, MODE, FREEZE,
        input  VGA_R, VGA_G, VGA_B, HSYNC, VSYNC, HBLANK, VBLANK, FRAME_START
    );
endinterface

// File: rtl/dac_pattern_gen.sv
// Video DAC test pattern generator: raster timing plus four selectable RGB patterns.
// Optional macro DAC_TEST_BORDER_EN forces an all-ones one-pixel border around the active area.
module dac_pattern_gen #(
    parameter int COLOR_W     = 8,
    parameter int HOLD_CYCLES = 12000000,
    parameter int H_ACTIVE    = 320,
    parameter int H_TOTAL     = 384,
    parameter int HS_START    = 336,
    parameter int HS_LEN      = 29,
    parameter int V_ACTIVE    = 224,
    parameter int V_TOTAL     = 264,
    parameter int VS_START    = 240,
    parameter int VS_LEN      = 3,
    parameter int CELL_LOG2   = 4
) (
    input  logic              CLK_24M,
    input  logic              RESET,
    dac_pattern_gen_if.master vid
);
    localparam int H_W     = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int V_W     = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    localparam int T_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int BAR_PIX = H_ACTIVE / 8;
    localparam int P_W     = (BAR_PIX > 1) ? $clog2(BAR_PIX) : 1;

    typedef logic [H_W-1:0] h_t;
    typedef logic [H_W:0]   hx_t;
    typedef logic [V_W-1:0] v_t;
    typedef logic [V_W:0]   vx_t;
    typedef logic [T_W-1:0] t_t;
    typedef logic [P_W-1:0] p_t;

    localparam h_t  H_LAST    = h_t'(H_TOTAL - 1);
    localparam v_t  V_LAST    = v_t'(V_TOTAL - 1);
    localparam t_t  T_LAST    = t_t'(HOLD_CYCLES - 1);
    localparam p_t  BAR_LAST  = p_t'(BAR_PIX - 1);
    localparam hx_t HX_ACTIVE = hx_t'(H_ACTIVE);
    localparam hx_t HX_HS_BEG = hx_t'(HS_START);
    localparam hx_t HX_HS_END = hx_t'(HS_START + HS_LEN);
    localparam vx_t VX_ACTIVE = vx_t'(V_ACTIVE);
    localparam vx_t VX_VS_BEG = vx_t'(VS_START);
    localparam vx_t VX_VS_END = vx_t'(VS_START + VS_LEN);
`ifdef DAC_TEST_BORDER_EN
    localparam h_t  H_ACT_LAST = h_t'(H_ACTIVE - 1);
    localparam v_t  V_ACT_LAST = v_t'(V_ACTIVE - 1);
`endif

    h_t                 h_cnt_q, h_cnt_d;
    v_t                 v_cnt_q, v_cnt_d;
    logic [2:0]         bar_idx_q, bar_idx_d;
    p_t                 bar_pix_q, bar_pix_d;
    logic [1:0]         mode_q, mode_d;
    logic               wrap_q, wrap_d;
    t_t                 timer_q, timer_d;
    logic [2:0]         color_idx_q, color_idx_d;
    logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic               hsync_q, hsync_d, vsync_q, vsync_d;
    logic               hblank_q, hblank_d, vblank_q, vblank_d;
    logic               frame_start_q, frame_start_d;

    hx_t                hx;
    vx_t                vx;
    logic [2:0]         rgb_on;
    logic               use_grey;
    logic [COLOR_W-1:0] grey;

    // Raster, bar tracking and mode latch; everything steps only on PCLK_EN.
    always_comb begin
        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        bar_idx_d = bar_idx_q;
        bar_pix_d = bar_pix_q;
        mode_d    = mode_q;
        wrap_d    = 1'b0;
        if (vid.PCLK_EN) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d   = '0;
                bar_idx_d = '0;
                bar_pix_d = '0;
                if (v_cnt_q == V_LAST) begin
                    v_cnt_d = '0;
                    mode_d  = vid.MODE;
                    wrap_d  = 1'b1;
                end else begin
                    v_cnt_d = v_cnt_q + 1'b1;
                end
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
                if (bar_pix_q == BAR_LAST) begin
                    bar_pix_d = '0;
                    bar_idx_d = bar_idx_q + 1'b1;
                end else begin
                    bar_pix_d = bar_pix_q + 1'b1;
                end
            end
        end
    end

    // Solid-colour timer free-runs on every clock so mode 0 resumes mid-sequence.
    always_comb begin
        timer_d     = timer_q + 1'b1;
        color_idx_d = color_idx_q;
        if (timer_q == T_LAST) begin
            timer_d = '0;
            if (!vid.FREEZE) begin
                color_idx_d = color_idx_q + 1'b1;
            end
        end
    end

    // Output stage sees the current counter state, so outputs trail it by one clock.
    always_comb begin
        hx       = {1'b0, h_cnt_q};
        vx       = {1'b0, v_cnt_q};
        hblank_d = (hx >= HX_ACTIVE);
        vblank_d = (vx >= VX_ACTIVE);
        hsync_d  = !((hx >= HX_HS_BEG) && (hx < HX_HS_END));
        vsync_d  = !((vx >= VX_VS_BEG) && (vx < VX_VS_END));
        frame_start_d = wrap_q;
        grey     = COLOR_W'(h_cnt_q);
        rgb_on   = 3'b000;
        use_grey = 1'b0;
        case (mode_q)
            2'd0:    rgb_on = {color_idx_q[0], color_idx_q[1], color_idx_q[2]};
            2'd1:    rgb_on = ~{bar_idx_q[1], bar_idx_q[2], bar_idx_q[0]};
            2'd2:    use_grey = 1'b1;
            default: rgb_on = {3{h_cnt_q[CELL_LOG2] ^ v_cnt_q[CELL_LOG2]}};
        endcase
`ifdef DAC_TEST_BORDER_EN
        if (h_cnt_q == '0 || h_cnt_q == H_ACT_LAST || v_cnt_q == '0 || v_cnt_q == V_ACT_LAST) begin
            rgb_on   = 3'b111;
            use_grey = 1'b0;
        end
`endif
        if (use_grey) begin
            r_d = grey;
            g_d = grey;
            b_d = grey;
        end else begin
            r_d = {COLOR_W{rgb_on[2]}};
            g_d = {COLOR_W{rgb_on[1]}};
            b_d = {COLOR_W{rgb_on[0]}};
        end
        if (hblank_d || vblank_d) begin
            r_d = '0;
            g_d = '0;
            b_d = '0;
        end
    end

    always_ff @(posedge CLK_24M) begin
        if (RESET) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            bar_idx_q     <= '0;
            bar_pix_q     <= '0;
            mode_q        <= '0;
            wrap_q        <= 1'b0;
            timer_q       <= '0;
            color_idx_q   <= '0;
            r_q           <= '0;
            g_q           <= '0;
            b_q           <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            hblank_q      <= 1'b0;
            vblank_q      <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            bar_idx_q     <= bar_idx_d;
            bar_pix_q     <= bar_pix_d;
            mode_q        <= mode_d;
            wrap_q        <= wrap_d;
            timer_q       <= timer_d;
            color_idx_q   <= color_idx_d;
            r_q           <= r_d;
            g_q           <= g_d;
            b_q           <= b_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            hblank_q      <= hblank_d;
            vblank_q      <= vblank_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vid.VGA_R       = r_q;
    assign vid.VGA_G       = g_q;
    assign vid.VGA_B       = b_q;
    assign vid.HSYNC       = hsync_q;
    assign vid.VSYNC       = vsync_q;
    assign vid.HBLANK      = hblank_q;
    assign vid.VBLANK      = vblank_q;
    assign vid.FRAME_START = frame_start_q;
endmodule

// File: tb/tb_dac_pattern_gen.sv
// Self-checking bench for dac_pattern_gen: two instances (8-bit and 6-bit colour) on a
// reduced raster, compared every clock against a pixel-count based reference model.
module tb_dac_pattern_gen;
    localparam int HA = 80, HT = 96, HSS = 84, HSL = 6;
    localparam int VA = 24, VT = 30, VSS = 26, VSL = 3;
    localparam int CL = 3, HOLD = 10;
    localparam int FRAME = HT * VT;
    localparam logic [28:0] RST_A = {24'h0, 5'b11000};
    localparam logic [22:0] RST_B = {18'h0, 5'b11000};

    logic       clk = 1'b0;
    logic       rst;
    logic       pclk_en;
    logic [1:0] mode;
    logic       freeze;

    always #5 clk = ~clk;

    dac_pattern_gen_if #(.COLOR_W(8)) if_a ();
    dac_pattern_gen_if #(.COLOR_W(6)) if_b ();

    assign if_a.PCLK_EN = pclk_en;
    assign if_a.MODE    = mode;
    assign if_a.FREEZE  = freeze;
    assign if_b.PCLK_EN = pclk_en;
    assign if_b.MODE    = mode;
    assign if_b.FREEZE  = freeze;

    dac_pattern_gen #(.COLOR_W(8), .HOLD_CYCLES(HOLD), .H_ACTIVE(HA), .H_TOTAL(HT),
        .HS_START(HSS), .HS_LEN(HSL), .V_ACTIVE(VA), .V_TOTAL(VT), .VS_START(VSS),
        .VS_LEN(VSL), .CELL_LOG2(CL)) dut_a (.CLK_24M(clk), .RESET(rst), .vid(if_a));

    dac_pattern_gen #(.COLOR_W(6), .HOLD_CYCLES(HOLD), .H_ACTIVE(HA), .H_TOTAL(HT),
        .HS_START(HSS), .HS_LEN(HSL), .V_ACTIVE(VA), .V_TOTAL(VT), .VS_START(VSS),
        .VS_LEN(VSL), .CELL_LOG2(CL)) dut_b (.CLK_24M(clk), .RESET(rst), .vid(if_b));

    logic [28:0] act_a;
    logic [22:0] act_b;
    assign act_a = {if_a.VGA_R, if_a.VGA_G, if_a.VGA_B, if_a.HSYNC, if_a.VSYNC,
                    if_a.HBLANK, if_a.VBLANK, if_a.FRAME_START};
    assign act_b = {if_b.VGA_R, if_b.VGA_G, if_b.VGA_B, if_b.HSYNC, if_b.VSYNC,
                    if_b.HBLANK, if_b.VBLANK, if_b.FRAME_START};

    int n_tests = 0;
    int n_fail  = 0;

    // {R,G,B} full-scale flags, listed by bar number and by solid-cycle step
    int bar_tab   [8] = '{7, 6, 3, 2, 5, 4, 1, 0};
    int solid_tab [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    function automatic int pix(int w, int h, int v, int md, int idx);
        int ones, rgb3, grey;
        ones = (1 << w) - 1;
        rgb3 = 0;
        grey = -1;
        if (h >= HA || v >= VA) return 0;
        case (md)
            0:       rgb3 = solid_tab[idx];
            1:       rgb3 = bar_tab[h / (HA / 8)];
            2:       grey = h % (1 << w);
            default: rgb3 = (((h / (1 << CL)) % 2) != ((v / (1 << CL)) % 2)) ? 7 : 0;
        endcase
`ifdef DAC_TEST_BORDER_EN
        if (h == 0 || h == HA - 1 || v == 0 || v == VA - 1) begin
            rgb3 = 7;
            grey = -1;
        end
`endif
        if (grey >= 0) return (grey << 20) | (grey << 10) | grey;
        return ((((rgb3 >> 2) & 1) != 0 ? ones : 0) << 20) |
               ((((rgb3 >> 1) & 1) != 0 ? ones : 0) << 10) |
               (((rgb3 & 1) != 0) ? ones : 0);
    endfunction

    // Reference model: raster position derived from a count of enabled pixels since reset.
    int n_pix, n_clk, idx_m, mode_m;
    bit fs_flag;
    int m_h, m_v, pa, pb;
    bit m_hs, m_vs, m_hb, m_vb;
    logic [28:0] exp_a;
    logic [22:0] exp_b;

    always @(posedge clk) begin
        if (rst) begin
            n_pix = 0; n_clk = 0; idx_m = 0; mode_m = 0; fs_flag = 0;
            exp_a = RST_A;
            exp_b = RST_B;
        end else begin
            m_h  = n_pix % HT;
            m_v  = (n_pix / HT) % VT;
            pa   = pix(8, m_h, m_v, mode_m, idx_m);
            pb   = pix(6, m_h, m_v, mode_m, idx_m);
            m_hs = !(m_h >= HSS && m_h < HSS + HSL);
            m_vs = !(m_v >= VSS && m_v < VSS + VSL);
            m_hb = (m_h >= HA);
            m_vb = (m_v >= VA);
            exp_a = {pa[27:20], pa[17:10], pa[7:0], m_hs, m_vs, m_hb, m_vb, fs_flag};
            exp_b = {pb[25:20], pb[15:10], pb[5:0], m_hs, m_vs, m_hb, m_vb, fs_flag};
            fs_flag = 0;
            if (pclk_en) begin
                n_pix++;
                if (n_pix % FRAME == 0) begin
                    mode_m  = int'(mode);
                    fs_flag = 1;
                end
            end
            if ((n_clk % HOLD) == HOLD - 1 && !freeze) idx_m = (idx_m + 1) % 8;
            n_clk++;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pclk_en = 1'b1;
        mode = 2'($urandom_range(0, 3));
        freeze = 1'($urandom_range(0, 1));
        repeat (3) @(negedge clk);
        n_tests++;
        if (act_a !== RST_A) begin
            n_fail++;
            $display("FAIL reset_a: got %h expected %h", act_a, RST_A);
        end
        n_tests++;
        if (act_b !== RST_B) begin
            n_fail++;
            $display("FAIL reset_b: got %h expected %h", act_b, RST_B);
        end
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            n_tests++;
            if (act_a !== exp_a) begin
                n_fail++;
                $display("FAIL reset_exit cyc %0d: got %h expected %h", i, act_a, exp_a);
            end
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_sync();
        int fs_cnt, hs_low, vs_low;
        fs_cnt = 0; hs_low = 0; vs_low = 0;
        pclk_en = 1'b1;
        mode = 2'($urandom_range(0, 3));
        do_reset();
        for (int i = 1; i <= 2 * FRAME + 4; i++) begin
            @(negedge clk);
            n_tests++;
            if (act_a !== exp_a || act_b !== exp_b) begin
                n_fail++;
                $display("FAIL sync cyc %0d: got %h/%h expected %h/%h", i, act_a, act_b, exp_a, exp_b);
            end
            if (if_a.FRAME_START) fs_cnt++;
            if (i <= HT && !if_a.HSYNC) hs_low++;
            if (i <= FRAME && !if_a.VSYNC) vs_low++;
            freeze = 1'($urandom_range(0, 1));
        end
        n_tests++;
        if (fs_cnt != 2) begin
            n_fail++;
            $display("FAIL frame_start_count: got %0d expected 2", fs_cnt);
        end
        n_tests++;
        if (hs_low != HSL) begin
            n_fail++;
            $display("FAIL hsync_width: got %0d expected %0d", hs_low, HSL);
        end
        n_tests++;
        if (vs_low != VSL * HT) begin
            n_fail++;
            $display("FAIL vsync_width: got %0d expected %0d", vs_low, VSL * HT);
        end
        $display("[TB] test_sync done, %0d frame starts", fs_cnt);
    endtask

    task automatic test_solid();
        pclk_en = 1'b1;
        mode = 2'd0;
        freeze = 1'b0;
        do_reset();
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            n_tests++;
            if (act_a !== exp_a) begin
                n_fail++;
                $display("FAIL solid cyc %0d: got %h expected %h", i, act_a, exp_a);
            end
            if (i == 15 || i == 25) begin
                n_tests++;
                if (act_a[28:5] !== ((i == 15) ? 24'hFF0000 : 24'h00FF00)) begin
                    n_fail++;
                    $display("FAIL solid_step cyc %0d: got %h", i, act_a[28:5]);
                end
            end
            if (i < 100)      freeze = 1'b0;
            else if (i < 130) freeze = 1'b1;
            else if (i < 180) freeze = 1'b0;
            else              freeze = 1'($urandom_range(0, 1));
        end
        $display("[TB] test_solid done");
    endtask

    task automatic test_bars();
        logic [23:0] want;
        pclk_en = 1'b1;
        mode = 2'd1;
        do_reset();
        for (int i = 1; i <= FRAME + 2 * HT; i++) begin
            @(negedge clk);
            n_tests++;
            if (act_a !== exp_a) begin
                n_fail++;
                $display("FAIL bars cyc %0d: got %h expected %h", i, act_a, exp_a);
            end
            if (i == FRAME + 1 || i == FRAME + 11 || i == FRAME + 71 || i == FRAME + 81) begin
                want = (i == FRAME + 1) ? 24'hFFFFFF : (i == FRAME + 11) ? 24'hFFFF00 : 24'h000000;
                n_tests++;
                if (act_a[28:5] !== want) begin
                    n_fail++;
                    $display("FAIL bar_pixel cyc %0d: got %h expected %h", i, act_a[28:5], want);
                end
            end
        end
        $display("[TB] test_bars done");
    endtask

    task automatic test_grey();
        pclk_en = 1'b1;
        mode = 2'd2;
        do_reset();
        for (int i = 1; i <= FRAME + HT; i++) begin
            @(negedge clk);
            n_tests++;
            if (act_a !== exp_a || act_b !== exp_b) begin
                n_fail++;
                $display("FAIL grey cyc %0d: got %h/%h expected %h/%h", i, act_a, act_b, exp_a, exp_b);
            end
            if (i == FRAME + 64 || i == FRAME + 65) begin
                n_tests++;
                if (act_b[22:5] !== ((i == FRAME + 64) ? 18'h3FFFF : 18'h0)) begin
                    n_fail++;
                    $display("FAIL grey_wrap cyc %0d: got %h", i, act_b[22:5]);
                end
            end
        end
        $display("[TB] test_grey done");
    endtask

    task automatic test_mode_change();
        pclk_en = 1'b1;
        mode = 2'd1;
        do_reset();
        for (int i = 1; i <= 2 * FRAME + 9 * HT; i++) begin
            @(negedge clk);
            n_tests++;
            if (act_a !== exp_a) begin
                n_fail++;
                $display("FAIL mode_change cyc %0d: got %h expected %h", i, act_a, exp_a);
            end
            if (i == FRAME + 20 * HT + 1 || i == 2 * FRAME + 9 || i == 2 * FRAME + 8 * HT + 9) begin
                n_tests++;
                if (act_a[28:5] !== ((i == 2 * FRAME + 8 * HT + 9) ? 24'h000000 : 24'hFFFFFF)) begin
                    n_fail++;
                    $display("FAIL mode_change_pixel cyc %0d: got %h", i, act_a[28:5]);
                end
            end
            if (i == FRAME + 10 * HT) mode = 2'd3;
        end
        $display("[TB] test_mode_change done");
    endtask

    task automatic test_back_to_back();
        mode = 2'($urandom_range(0, 3));
        pclk_en = 1'b0;
        do_reset();
        for (int i = 1; i <= 4 * 12 * HT; i++) begin
            pclk_en = (i % 4 == 0);
            @(negedge clk);
            n_tests++;
            if (act_a !== exp_a) begin
                n_fail++;
                $display("FAIL quarter_rate cyc %0d: got %h expected %h", i, act_a, exp_a);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (act_a !== RST_A || act_b !== RST_B) begin
            n_fail++;
            $display("FAIL mid_reset: got %h/%h expected %h/%h", act_a, act_b, RST_A, RST_B);
        end
        rst = 1'b0;
        for (int i = 1; i <= 3000; i++) begin
            pclk_en = 1'($urandom_range(0, 1));
            mode = 2'($urandom_range(0, 3));
            freeze = 1'($urandom_range(0, 1));
            @(negedge clk);
            n_tests++;
            if (act_a !== exp_a || act_b !== exp_b) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %h/%h expected %h/%h", i, act_a, act_b, exp_a, exp_b);
            end
        end
        $display("[TB] test_back_to_back done");
    endtask

    initial begin
        rst = 1'b1;
        pclk_en = 1'b0;
        mode = 2'd0;
        freeze = 1'b0;
        test_reset();
        test_sync();
        test_solid();
        test_bars();
        test_grey();
        test_mode_change();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
